// File: rtl/sar_adc_seq.sv
// sar_adc_seq: successive-approximation sequencer for the adc_dac analog macro.
// Scans the enabled channels in ascending order. Each channel is sampled,
// resolved MSB-first through its DAC and comparator, and its result is kept
// with a sticky valid flag for the host.
module sar_adc_seq #(
    parameter int NUM_CH     = 4,
    parameter int RES_BITS   = 8,
    parameter int SAMPLE_CYC = 4
) (
    input  logic                         mclk,
    input  logic                         reset_n,
    input  logic                         cfg_start,
    input  logic                         cfg_cont,
    input  logic [NUM_CH-1:0]            cfg_ch_en,
    input  logic [7:0]                   cfg_settle,
    output logic [NUM_CH*RES_BITS-1:0]   dac_code,
    output logic [NUM_CH-1:0]            adc_sample,
    input  logic [NUM_CH-1:0]            comp_in,
    output logic [NUM_CH*RES_BITS-1:0]   result,
    output logic [NUM_CH-1:0]            result_vld,
    input  logic [NUM_CH-1:0]            result_clr,
    output logic                         busy,
    output logic                         scan_done
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int BIT_W = (RES_BITS > 1) ? $clog2(RES_BITS) : 1;
    localparam int SC_W  = $clog2(SAMPLE_CYC + 1);

    localparam logic [BIT_W-1:0] TOP_BIT     = BIT_W'(RES_BITS - 1);
    localparam logic [SC_W-1:0]  SAMPLE_LOAD = SC_W'(SAMPLE_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SAMPLE,
        S_TRIAL,
        S_DECIDE,
        S_STORE,
        S_NEXT
    } state_t;

    // Single-bit mask selecting trial bit b of a conversion word.
    function automatic logic [RES_BITS-1:0] bit_mask(input logic [BIT_W-1:0] b);
        return RES_BITS'(1) << b;
    endfunction

    // One-hot channel strobe pattern.
    function automatic logic [NUM_CH-1:0] ch_onehot(input logic [CH_W-1:0] c);
        return NUM_CH'(1) << c;
    endfunction

    // Lowest set bit of mask at or above start. MSB of the return is the
    // "found" flag, the rest is the channel index.
    function automatic logic [CH_W:0] find_from(input logic [NUM_CH-1:0] mask,
                                                input int               start);
        logic [CH_W:0] hit;
        hit = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (i >= start && mask[i]) begin
                hit = {1'b1, CH_W'(i)};
            end
        end
        return hit;
    endfunction

    state_t              state;
    logic [NUM_CH-1:0]   en_q;
    logic [CH_W-1:0]     ch_q;
    logic [BIT_W-1:0]    bit_q;
    logic [RES_BITS-1:0] work_q;
    logic [SC_W-1:0]     samp_cnt;
    logic [8:0]          trial_cnt;
    logic [NUM_CH-1:0]   sync1;
    logic [NUM_CH-1:0]   sync2;

    logic [CH_W:0]       first_hit;
    logic [CH_W:0]       next_hit;
    logic [8:0]          settle_load;
    logic                comp_sel;
    logic [RES_BITS-1:0] kept;
    logic [RES_BITS-1:0] next_work;

    // First channel of a freshly latched mask, and the next one after ch_q.
    assign first_hit = find_from(cfg_ch_en, 0);
    assign next_hit  = find_from(en_q, int'(ch_q) + 1);

    // TRIAL lasts settle_eff+2 cycles; the counter runs down to zero, so it
    // is loaded with settle_eff+1. A settle value of 0 behaves like 1.
    assign settle_load = (cfg_settle == 8'd0) ? 9'd2 : ({1'b0, cfg_settle} + 9'd1);

    // Two-flop synchroniser for the asynchronous comparator lines.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its source; blocking here would collapse
    // the two synchroniser stages into one.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= comp_in;
            sync2 <= sync1;
        end
    end

    // Trial decision: keep or drop the current bit, and form the next trial word.
    // NOTE: every combinational output gets a default at the top of the block,
    // so no path can leave one unassigned and infer a latch.
    always_comb begin
        comp_sel  = 1'b0;
        kept      = work_q;
        next_work = work_q;
        comp_sel  = sync2[ch_q];
        if (!comp_sel) begin
            kept = work_q & ~bit_mask(bit_q);
        end
        next_work = kept | bit_mask(bit_q - 1'b1);
    end

    // Sequencer FSM with registered outputs and result storage.
    // NOTE: the result words are ordinary flops, not a RAM, and the host must
    // read zero after reset, so they are cleared with the rest of the state.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            en_q       <= '0;
            ch_q       <= '0;
            bit_q      <= '0;
            work_q     <= '0;
            samp_cnt   <= '0;
            trial_cnt  <= '0;
            dac_code   <= '0;
            adc_sample <= '0;
            result     <= '0;
            result_vld <= '0;
            busy       <= 1'b0;
            scan_done  <= 1'b0;
        end else begin
            scan_done  <= 1'b0;
            // Host clears first; a STORE below on the same bit overrides it.
            result_vld <= result_vld & ~result_clr;

            case (state)
                S_IDLE: begin
                    if (cfg_start) begin
                        en_q <= cfg_ch_en;
                        if (first_hit[CH_W]) begin
                            ch_q       <= first_hit[CH_W-1:0];
                            adc_sample <= ch_onehot(first_hit[CH_W-1:0]);
                            samp_cnt   <= SAMPLE_LOAD;
                            busy       <= 1'b1;
                            state      <= S_SAMPLE;
                        end else begin
                            // Empty mask: an empty scan that ends at once.
                            scan_done <= 1'b1;
                        end
                    end
                end

                S_SAMPLE: begin
                    if (samp_cnt == '0) begin
                        adc_sample <= '0;
                        bit_q      <= TOP_BIT;
                        work_q     <= bit_mask(TOP_BIT);
                        dac_code[int'(ch_q)*RES_BITS +: RES_BITS] <= bit_mask(TOP_BIT);
                        trial_cnt  <= settle_load;
                        state      <= S_TRIAL;
                    end else begin
                        samp_cnt <= samp_cnt - 1'b1;
                    end
                end

                S_TRIAL: begin
                    if (trial_cnt == 9'd0) begin
                        state <= S_DECIDE;
                    end else begin
                        trial_cnt <= trial_cnt - 9'd1;
                    end
                end

                S_DECIDE: begin
                    if (bit_q == '0) begin
                        work_q <= kept;
                        state  <= S_STORE;
                    end else begin
                        bit_q     <= bit_q - 1'b1;
                        work_q    <= next_work;
                        dac_code[int'(ch_q)*RES_BITS +: RES_BITS] <= next_work;
                        trial_cnt <= settle_load;
                        state     <= S_TRIAL;
                    end
                end

                S_STORE: begin
                    result[int'(ch_q)*RES_BITS +: RES_BITS]   <= work_q;
                    result_vld[ch_q]                          <= 1'b1;
                    dac_code[int'(ch_q)*RES_BITS +: RES_BITS] <= '0;
                    state                                     <= S_NEXT;
                end

                S_NEXT: begin
                    if (next_hit[CH_W]) begin
                        ch_q       <= next_hit[CH_W-1:0];
                        adc_sample <= ch_onehot(next_hit[CH_W-1:0]);
                        samp_cnt   <= SAMPLE_LOAD;
                        state      <= S_SAMPLE;
                    end else begin
                        scan_done <= 1'b1;
                        if (cfg_cont) begin
                            en_q <= cfg_ch_en;
                        end
                        if (cfg_cont && first_hit[CH_W]) begin
                            // Back-to-back scan: busy stays high.
                            ch_q       <= first_hit[CH_W-1:0];
                            adc_sample <= ch_onehot(first_hit[CH_W-1:0]);
                            samp_cnt   <= SAMPLE_LOAD;
                            state      <= S_SAMPLE;
                        end else begin
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
